// File: rtl/mm2s_ram_reader_if.sv
// ---------------------------------------------------------------------------
// mm2s_ram_reader_if
//   Bundles the three bus groups of the RAM-to-stream reader:
//     cmd_*     : command channel (start byte address, beats minus one)
//     mem_*     : 1-cycle-latency word RAM read port
//     m_axis_*  : AXI-Stream master output
//   Modport "master" is the reader's view of these signals.
//   Modport "slave" is the surrounding environment's view: the command
//   source, the RAM and the stream sink.
// ---------------------------------------------------------------------------
interface mm2s_ram_reader_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_W          = 16
);
  localparam int LSB = $clog2(AXI_WIDTH) - 3;

  // Command channel
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [AXI_ADDR_WIDTH-1:0]       cmd_addr;
  logic [LEN_W-1:0]                cmd_beats;

  // RAM read port
  logic                            mem_ren;
  logic [AXI_ADDR_WIDTH-LSB-1:0]   mem_addr;
  logic [AXI_WIDTH-1:0]            mem_data;

  // AXI-Stream output
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [AXI_WIDTH-1:0]            m_axis_tdata;
  logic                            m_axis_tlast;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats, mem_data, m_axis_tready,
    output cmd_ready, mem_ren, mem_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats, mem_data, m_axis_tready,
    input  cmd_ready, mem_ren, mem_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/mm2s_ram_reader.sv
// ---------------------------------------------------------------------------
// mm2s_ram_reader
//   Read-side DMA stage. Takes a (byte address, beats-minus-one) command,
//   issues sequential word reads to a 1-cycle-latency RAM and streams the
//   returned words out as one AXI-Stream burst terminated by tlast.
//   Sustains one beat per cycle and honours arbitrary backpressure.
//
// Ports
//   clk     : clock, everything on the rising edge
//   rst     : synchronous active-high reset; aborts any burst in progress
//   bus_if  : mm2s_ram_reader_if.master (command, RAM read port, stream out)
//   busy_o  : high while a command is being processed
//   done_o  : one-cycle pulse coincident with the tlast handshake
// ---------------------------------------------------------------------------
module mm2s_ram_reader #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mm2s_ram_reader_if.master      bus_if,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int LSB   = $clog2(AXI_WIDTH) - 3;
  localparam int PTR_W = AXI_ADDR_WIDTH - LSB;
  localparam int REM_W = LEN_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Control state
  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wordPtr_q, wordPtr_d;
  logic [REM_W-1:0]     remaining_q, remaining_d;
  logic                 inflight_q, inflight_d;
  logic                 inflightLast_q, inflightLast_d;

  // Two-entry output FIFO
  logic [AXI_WIDTH-1:0] fifoData_q [0:1];
  logic                 fifoLast_q [0:1];
  logic                 wrPtr_q, wrPtr_d;
  logic                 rdPtr_q, rdPtr_d;
  logic [1:0]           count_q, count_d;

  // Handshake and datapath helpers
  logic                 cmdReady;
  logic                 cmdFire;
  logic                 memRen;
  logic                 outValid;
  logic                 pop;
  logic                 fifoEmpty;
  logic                 pushFifo;
  logic                 popFifo;
  logic                 headLast;
  logic [AXI_WIDTH-1:0] headData;
  logic [2:0]           occAfterPop;

  // Low byte-offset bits of the command address select nothing: reads are
  // whole words. They are folded here so they are visibly consumed.
  logic                 unused_addrLsb;
  assign unused_addrLsb = ^bus_if.cmd_addr[LSB-1:0];

  // The word returning from RAM this cycle is presented directly when the
  // FIFO is empty, so the first beat appears one cycle after its read and a
  // steady burst has no bubbles. A returned word that is not taken
  // immediately drops into the FIFO, which keeps tdata/tlast stable under
  // backpressure because the RAM holds mem_data until the next read.
  always_comb begin
    fifoEmpty = (count_q == 2'd0);
    outValid  = !fifoEmpty || inflight_q;
    headData  = fifoEmpty ? bus_if.mem_data : fifoData_q[rdPtr_q];
    headLast  = fifoEmpty ? inflightLast_q  : fifoLast_q[rdPtr_q];
    pop       = outValid && bus_if.m_axis_tready;
    popFifo   = !fifoEmpty && bus_if.m_axis_tready;
    pushFifo  = inflight_q && !(fifoEmpty && bus_if.m_axis_tready);
  end

  // Read issue credit: words held plus the word in flight, minus the one
  // leaving this cycle, must leave room for the new read. This caps the
  // reader at two words ahead of the consumer, so the FIFO never overflows.
  always_comb begin
    cmdReady    = (state_q == IDLE) && !rst;
    cmdFire     = bus_if.cmd_valid && cmdReady;
    occAfterPop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    memRen      = (state_q == READ) && (remaining_q != '0) && (occAfterPop < 3'd2);
  end

  // Next-state logic for the command FSM, address pointer and beat counter.
  // The remaining counter is one bit wider than cmd_beats so that the
  // largest command (all ones, i.e. 2^LEN_W beats) still fits.
  always_comb begin
    state_d        = state_q;
    wordPtr_d      = wordPtr_q;
    remaining_d    = remaining_q;
    inflight_d     = memRen;
    inflightLast_d = memRen && (remaining_q == REM_W'(1));
    unique case (state_q)
      IDLE: begin
        if (cmdFire) begin
          state_d     = READ;
          wordPtr_d   = bus_if.cmd_addr[AXI_ADDR_WIDTH-1:LSB];
          remaining_d = {1'b0, bus_if.cmd_beats} + REM_W'(1);
        end
      end
      READ: begin
        if (memRen) begin
          wordPtr_d   = wordPtr_q + PTR_W'(1);
          remaining_d = remaining_q - REM_W'(1);
        end
        if (pop && headLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wrPtr_d = pushFifo ? !wrPtr_q : wrPtr_q;
    rdPtr_d = popFifo  ? !rdPtr_q : rdPtr_q;
    count_d = count_q + {1'b0, pushFifo} - {1'b0, popFifo};
  end

  // Control registers. Reset drops the in-flight read and empties the
  // FIFO, so an aborted burst never emits tlast or done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wordPtr_q      <= '0;
      remaining_q    <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      wrPtr_q        <= 1'b0;
      rdPtr_q        <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      state_q        <= state_d;
      wordPtr_q      <= wordPtr_d;
      remaining_q    <= remaining_d;
      inflight_q     <= inflight_d;
      inflightLast_q <= inflightLast_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage has no reset; entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (!rst && pushFifo) begin
      fifoData_q[wrPtr_q] <= bus_if.mem_data;
      fifoLast_q[wrPtr_q] <= inflightLast_q;
    end
  end

  // Output drive
  assign bus_if.cmd_ready     = cmdReady;
  assign bus_if.mem_ren       = memRen;
  assign bus_if.mem_addr      = wordPtr_q;
  assign bus_if.m_axis_tvalid = outValid;
  assign bus_if.m_axis_tdata  = headData;
  assign bus_if.m_axis_tlast  = headLast;
  assign busy_o               = (state_q == READ);
  assign done_o               = pop && headLast;

endmodule
